alu_op_sequencer: RTL

//  Initiator side of the registered-ALU interface (en/fun/a/b in, out/carry back).

---
 rtl/alu_op_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Instruction sequencer driving a registered ALU: decodes, issues one op,
// waits ALU_LAT cycles, then writes the result into a 4-entry register file.
module alu_op_sequencer #(
  parameter int ALU_LAT = 2,
  parameter int W       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [13:0]  instr,
  output logic         alu_en,
  output logic [3:0]   alu_fun,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_out,
  input  logic         alu_carry,
  output logic         done,
  output logic         err,
  input  logic         err_clr,
  output logic         carry_flag,
  input  logic [1:0]   rd_sel,
  output logic [W-1:0] rd_data
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rf_q [4];
  logic [W-1:0]  rf_d [4];
  logic [3:0]    fun_q, fun_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [1:0]    rd_q, rd_d;
  logic          err_q, err_d;
  logic          carry_q, carry_d;

  logic [1:0] i_cls;
  logic [3:0] i_fun;
  logic [1:0] i_rd;
  logic [1:0] i_ra;
  logic [1:0] i_rb;
  logic [3:0] i_imm;
  logic       fun_ok;
  logic       hs;

  assign i_cls = instr[13:12];
  assign i_fun = instr[11:8];
  assign i_rd  = instr[7:6];
  assign i_ra  = instr[5:4];
  assign i_rb  = instr[3:2];
  assign i_imm = instr[3:0];

  // legal: 1000, 1001 and 0000..0101
  assign fun_ok = i_fun[3] ? (i_fun[2:1] == 2'b00)
                           : (i_fun[2:1] != 2'b11);

  assign instr_ready = (state_q == IDLE);
  assign hs          = instr_valid & instr_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rf_d    = rf_q;
    fun_d   = fun_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    carry_d = carry_q;
    err_d   = err_q & ~err_clr;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          unique case (i_cls)
            2'b00: begin
              if (fun_ok) begin
                fun_d   = i_fun;
                a_d     = rf_q[i_ra];
                b_d     = rf_q[i_rb];
                rd_d    = i_rd;
                state_d = ISSUE;
              end else begin
                err_d = 1'b1;
              end
            end
            2'b01:   rf_d[i_rd] = W'(i_imm);
            2'b10:   ;
            default: err_d = 1'b1;
          endcase
        end
      end
      ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = (ALU_LAT == 1) ? WB : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = WB;
      end
      WB: begin
        rf_d[rd_q] = alu_out;
        carry_d    = alu_carry;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      fun_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rf_q    <= rf_d;
      fun_q   <= fun_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      carry_q <= carry_d;
    end
  end

  assign alu_en     = (state_q == ISSUE);
  assign done       = (state_q == WB);
  assign alu_fun    = fun_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign err        = err_q;
  assign carry_flag = carry_q;
  assign rd_data    = rf_q[rd_sel];

endmodule
